// File: rtl/spm_pkg.sv
// spm_pkg: definitions shared by the serial-multiplier host and its core.
//   SPM_N       default operand width (the product is 2*SPM_N bits)
//   spm_state_t host FSM encoding: IDLE=0, CLEAR=1, SHIFT=2, DONE=3
//   cnt_width() width of the SHIFT cycle counter, which spans 0..2N
package spm_pkg;

  localparam int SPM_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spm_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/spm_core.sv
// spm_core: bit-serial signed multiplier core (parallel x, serial y).
// Each cycle the serial bit y selects whether the sign-extended x is added
// into the running accumulator. The sum's LSB is the next product bit, and
// the rest of the sum is kept (arithmetic shift right by one). The product
// bit comes out of a flop, so it appears one cycle after its y bit.
//   clk  clock
//   rst  synchronous active-high clear (driven by the host's mult_clr)
//   x    parallel signed multiplicand, N bits
//   y    serial multiplier bit, LSB first (sign-extended by the host)
//   p    serial product bit, LSB first, one cycle behind y
module spm_core #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic         y,
  output logic         p
);

  // The carried value stays strictly below |x| in magnitude, so N+1 bits
  // hold it and N+2 bits hold acc + x without overflow.
  logic [N:0]   acc_reg;
  logic         p_reg;
  logic [N+1:0] addend;
  logic [N+1:0] sum;

  always_comb begin
    addend = '0;
    if (y) begin
      addend = {{2{x[N-1]}}, x};
    end
    sum = {acc_reg[N], acc_reg} + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      p_reg   <= 1'b0;
    end else begin
      acc_reg <= sum[N+1:1];
      p_reg   <= sum[0];
    end
  end

  assign p = p_reg;

endmodule

// File: rtl/spm_host.sv
// spm_host: valid/ready wrapper that runs a bit-serial signed multiplier core.
// It accepts an operand pair in IDLE and pulses the core clear in CLEAR. It
// then streams 2N+1 multiplier bits in SHIFT and collects the serial product
// into p_reg. It presents the 2N-bit product in DONE until it is taken.
//   clk, rst   clock; asynchronous active-high reset
//   in_valid / in_ready / in_x / in_y     operand pair handshake
//   out_valid / out_ready / out_p         product handshake
//   mult_clr / mult_x / mult_y / mult_p   connection to the serial core
//   busy       high whenever the FSM is not in IDLE
module spm_host
  import spm_pkg::*;
#(
  parameter int N = SPM_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           mult_clr,
  output logic [N-1:0]   mult_x,
  output logic           mult_y,
  input  logic           mult_p,
  output logic           busy
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_HALF = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * N);

  spm_state_t     state_reg;
  spm_state_t     state_next;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   x_reg;
  logic [N-1:0]   y_reg;
  logic [2*N-1:0] p_reg;
  logic [N-1:0]   y_shifted;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (in_valid)             state_next = ST_CLEAR;
      ST_CLEAR:                           state_next = ST_SHIFT;
      ST_SHIFT: if (cnt_reg == CNT_LAST)  state_next = ST_DONE;
      ST_DONE:  if (out_ready)            state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // SHIFT cycle index c; cleared during CLEAR so the first SHIFT cycle is c=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_SHIFT) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Operands are captured only on the IDLE handshake. They stay put while
  // busy, so in_x/in_y are free to change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (state_reg == ST_IDLE && in_valid) begin
      x_reg <= in_x;
      y_reg <= in_y;
    end
  end

  // The core's product bit lags its y bit by one cycle. Cycle c=0 therefore
  // carries nothing useful. Cycles 1..2N deliver product bits 0..2N-1, and
  // after 2N right shifts bit k lands in p_reg[k].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg <= '0;
    end else if (state_reg == ST_SHIFT && cnt_reg != '0) begin
      p_reg <= {mult_p, p_reg[2*N-1:1]};
    end
  end

  assign y_shifted = y_reg >> cnt_reg;

  // Output decode: from state and registered data only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mult_clr  = 1'b0;
    mult_x    = '0;
    mult_y    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_CLEAR: begin
        mult_clr = 1'b1;
        mult_x   = x_reg;
      end
      ST_SHIFT: begin
        mult_x = x_reg;
        // y bits LSB first, then y's sign bit to extend it to 2N bits, then
        // a trailing 0 that flushes the last product bit out of the core.
        if (cnt_reg < CNT_HALF) begin
          mult_y = y_shifted[0];
        end else if (cnt_reg < CNT_LAST) begin
          mult_y = y_reg[N-1];
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign out_p = p_reg;

endmodule
